// File: rtl/sample_stream_decoder.sv
// sample_stream_decoder: reassembles 14-bit samples from {1,d[13:7]} / {0,d[6:0]} byte pairs into a FWFT FIFO
// Ports:
//   clk_i, reset_ni                         clock, asynchronous active-low reset
//   byte_i, byte_valid_i, byte_ready_o      byte stream input handshake
//   sample_o, sample_valid_o, sample_ready_i sample output handshake (FIFO head)
//   frame_err_o                             one-cycle pulse per framing error
//   fill_o                                  FIFO entries in use
//   err_count_o                             saturating error count when SAMPLE_DEC_ERRCNT_EN is defined, else 0
module sample_stream_decoder #(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [7:0]             byte_i,
    input  logic                   byte_valid_i,
    output logic                   byte_ready_o,
    output logic [13:0]            sample_o,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic                   frame_err_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic [15:0]            err_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PINC = (AW+1)'(1);
    typedef enum logic {HUNT, HAVE_HI} state_t;
    state_t      state_q, state_d;
    logic [6:0]  hi_q, hi_d;
    logic [13:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, accept, push, pop, err_d;
    assign empty          = wr_ptr == rd_ptr;
    assign full           = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Stall only when the next byte could complete a sample into a full FIFO.
    assign byte_ready_o   = reset_ni & ~(state_q == HAVE_HI & full);
    assign accept         = byte_valid_i & byte_ready_o;
    assign sample_valid_o = ~empty;
    // The RAM is not reset, so the head is masked while empty.
    assign sample_o       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop            = sample_valid_o & sample_ready_i;
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        push    = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (byte_i[7]) begin
                        hi_d    = byte_i[6:0];
                        state_d = HAVE_HI;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                HAVE_HI: begin
                    if (!byte_i[7]) begin
                        push    = 1'b1;
                        state_d = HUNT;
                    end else begin
                        // Resync on the newest header.
                        err_d = 1'b1;
                        hi_d  = byte_i[6:0];
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= HUNT;
            hi_q        <= '0;
            frame_err_o <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_o      <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            frame_err_o <= err_d;
            if (push) wr_ptr <= wr_ptr + PINC;
            if (pop) rd_ptr <= rd_ptr + PINC;
            if (push & ~pop) fill_o <= fill_o + PINC;
            else if (pop & ~push) fill_o <= fill_o - PINC;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {hi_q, byte_i[6:0]};
    end
`ifdef SAMPLE_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) err_cnt_q <= '0;
        else if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = 16'h0000;
`endif
endmodule

// File: doc/sample_stream_decoder.md
# sample_stream_decoder

- Reassembles 14-bit audio samples from the two-byte host framing: header byte `{1, d[13:7]}`, then trailer byte `{0, d[6:0]}`.
- Sits between the FT2232H FIFO byte receiver and the DAC sample path, which is the reader side of the stream the host-link encoder writes.
- Recovers byte sync from the flag bit, buffers completed samples in a small FIFO and flags framing errors.

## Interface

Parameters:
- DEPTH, 4, sample FIFO depth in entries; power of two, ≥2.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- reset_ni  in  1  reset, asynchronous, active-low.
- byte_i  in  8  received byte from the FIFO interface.
- byte_valid_i  in  1  byte_i valid this cycle.
- byte_ready_o  out  1  decoder accepts byte_i this cycle; a byte transfers when byte_valid_i & byte_ready_o.
- sample_o  out  14  sample at FIFO head.
- sample_valid_o  out  1  sample_o valid (FIFO not empty).
- sample_ready_i  in  1  consumer takes sample_o; a pop happens when sample_valid_o & sample_ready_i.
- frame_err_o  out  1  one-cycle pulse per framing error.
- fill_o  out  clog2(DEPTH)+1  number of FIFO entries in use.
- err_count_o  out  16  framing error count (see Configuration).

## Operation

- State machine with two states, evaluated only on an accepted byte:
  - HUNT:
    - byte_i[7]=1: latch byte_i[6:0] as hi, go to HAVE_HI.
    - byte_i[7]=0: pulse frame_err_o, discard the byte, stay in HUNT.
  - HAVE_HI:
    - byte_i[7]=0: push `{hi, byte_i[6:0]}` into the FIFO, go to HUNT.
    - byte_i[7]=1: pulse frame_err_o, replace hi with the new byte_i[6:0], stay in HAVE_HI (resync on the newest header).
- Assembly: sample = (hi << 7) | lo. This is pure concatenation; no arithmetic.
- byte_ready_o = reset_ni & ~(state==HAVE_HI & full).
  - A byte that would complete a sample is never accepted into a full FIFO, so no sample is ever dropped.
  - When full, the stall is conservative: a pop in the same cycle does not raise byte_ready_o.
- FIFO:
  - First-word-fall-through. sample_o = mem[rd_ptr]; sample_valid_o = ~empty.
  - Pointers are clog2(DEPTH)+1 bits and wrap naturally; full/empty are decided by MSB comparison.
  - Simultaneous push and pop when not empty: fill_o unchanged, order preserved.
  - Pop when empty and push when full cannot occur, by construction of the handshakes.
- Reset (asynchronous, any time, including mid-frame):
  - State returns to HUNT; hi, pointers and fill_o go to 0.
  - sample_o=0, sample_valid_o=0, frame_err_o=0, err_count_o=0; byte_ready_o=0 while reset_ni is low.
  - A half-received frame is lost. A trailer byte arriving after reset is therefore a framing error.

## Timing

- Latency: trailer accepted at edge N, sample visible on sample_o with sample_valid_o=1 after edge N (cycle N+1), when the FIFO was empty.
- Throughput: one byte per cycle when not stalled, so one sample every two cycles.
- frame_err_o is registered: high for exactly the one cycle after the offending byte is accepted.
- fill_o is registered and updates on the same edge as the push or pop.
- byte_ready_o is combinational from registered state and full only. It has no combinational path from byte_valid_i or sample_ready_i.

## Configuration

- SAMPLE_DEC_ERRCNT_EN defined:
  - err_count_o is a 16-bit counter incremented on every frame_err_o pulse.
  - It saturates at 0xFFFF and is cleared only by reset.
- SAMPLE_DEC_ERRCNT_EN undefined:
  - No counter logic is built; err_count_o is tied to 16'h0000.
  - frame_err_o behaviour is unchanged.

## Test plan

- Bytes 0x85, 0x23 with sample_ready_i=1 → one sample 0x02A3, sample_valid_o high one cycle after the trailer is accepted, frame_err_o never pulses.
- Stray 0x11 in HUNT, then 0x80, 0x00 → frame_err_o pulses once, then one sample 0x0000; err_count_o=1 with the macro defined, 0 without.
- Bytes 0x81, 0xFF, 0x00 → one frame_err_o pulse, exactly one sample 0x3F80 (resync to the second header).
- sample_ready_i=0, DEPTH+1 back-to-back frames with values 1..DEPTH+1:
  - fill_o reaches DEPTH.
  - byte_ready_o drops after the header of frame DEPTH+1 is accepted.
  - After sample_ready_i=1, samples emerge in order 1..DEPTH+1, with no loss and no duplicates.
- Header 0x85 accepted, reset_ni pulsed low mid-cycle, then 0x23 → all outputs at reset values during reset, then one frame_err_o pulse, no sample, fill_o=0.
- With the macro defined, 65 537 stray 0x00 bytes → err_count_o saturates at 0xFFFF; pulses continue.
